// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - shared constants and config record for the programmable divider
package freq_div_pkg;

    localparam int CFG_W     = 16;
    localparam int MIN_DIV   = 2;
    localparam int HIGH_AUTO = 0;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
    } cfg_t;

endpackage

// File: rtl/freq_div_cfg_check.sv
// rtl/freq_div_cfg_check.sv - legality check and auto high-time for an offered config
module freq_div_cfg_check
    import freq_div_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] high_in,
    output logic             ok,
    output logic [CNT_W-1:0] h
);

    always_comb begin
        h  = (high_in == CNT_W'(HIGH_AUTO)) ? (div_in >> 1) : high_in;
        ok = (div_in >= CNT_W'(MIN_DIV)) && (h < div_in);
    end

endmodule

// File: rtl/freq_divider_prog.sv
// rtl/freq_divider_prog.sv - programmable integer divider with duty control and boundary-aligned reconfig
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 4,
    parameter int DEFAULT_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] high_in,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_err,
    output logic             pend
);

    generate
        if (CNT_W != CFG_W) begin : g_bad_width
            $error("freq_divider_prog: CNT_W must match freq_div_pkg::CFG_W");
        end
        if (DEFAULT_DIV < MIN_DIV || longint'(DEFAULT_DIV) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_div
            $error("freq_divider_prog: DEFAULT_DIV out of range");
        end
        if (DEFAULT_HIGH < 1 || DEFAULT_HIGH >= DEFAULT_DIV) begin : g_bad_high
            $error("freq_divider_prog: DEFAULT_HIGH out of range");
        end
    endgenerate

    cfg_t             active;
    cfg_t             staged;
    logic [CNT_W-1:0] cnt;
    logic             cfg_ok;
    logic [CNT_W-1:0] cfg_h;
    logic             xfer;
    logic             period_end;

    freq_div_cfg_check #(.CNT_W(CNT_W)) u_cfg_check (
        .div_in  (div_in),
        .high_in (high_in),
        .ok      (cfg_ok),
        .h       (cfg_h)
    );

    assign cfg_ready  = ~pend;
    assign xfer       = cfg_valid & ~pend;
    assign period_end = (cnt == active.div - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            active.div  <= CNT_W'(DEFAULT_DIV);
            active.high <= CNT_W'(DEFAULT_HIGH);
            staged      <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            cfg_err     <= 1'b0;
            pend        <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            // Transfer needs pend=0 and apply needs pend=1, so they never collide.
            if (xfer) begin
                if (cfg_ok) begin
                    staged.div  <= div_in;
                    staged.high <= cfg_h;
                    pend        <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            if (en) begin
                clk_out <= (cnt < active.high);
                tick    <= (cnt == '0);
                if (period_end) begin
                    cnt <= '0;
                    if (pend) begin
                        active <= staged;
                        pend   <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                // Idle has no period to protect, so a staged config lands immediately.
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend) begin
                    active <= staged;
                    pend   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_divider_prog.sv
// tb/tb_freq_divider_prog.sv - scoreboard bench for freq_divider_prog
module tb_freq_divider_prog;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] div_in;
    logic [W-1:0] high_in;
    logic         clk_out;
    logic         tick;
    logic         cfg_err;
    logic         pend;

    int pass_cnt = 0;
    int total    = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp;

    freq_divider_prog #(.CNT_W(W), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .div_in    (div_in),
        .high_in   (high_in),
        .clk_out   (clk_out),
        .tick      (tick),
        .cfg_err   (cfg_err),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_period(input int d, input int h);
        for (int i = 0; i < d; i++)
            exp_q.push_back({1'(i < h), 1'(i == 0)});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; cfg_valid = 1'b0; div_in = '0; high_in = '0;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({clk_out, tick, cfg_err, pend, cfg_ready} !== 5'b00001)
            $display("FAIL reset_state got=%b want=00001", {clk_out, tick, cfg_err, pend, cfg_ready});
        else pass_cnt++;
    endtask

    task automatic test_default();
        do_reset();
        push_period(4, 2); push_period(4, 2); push_period(4, 2);
        for (int i = 0; i < 12; i++) begin
            step(); exp = exp_q.pop_front(); total++;
            if ({clk_out, tick} !== exp) $display("FAIL default cyc%0d got=%b want=%b", i + 1, {clk_out, tick}, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reconfig_mid_period();
        do_reset();
        push_period(4, 2); push_period(5, 2); push_period(5, 2);
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin cfg_valid = 1'b1; div_in = 5; high_in = 0; end
            if (i == 3) cfg_valid = 1'b0;
            step(); exp = exp_q.pop_front(); total++;
            if ({clk_out, tick} !== exp) $display("FAIL reconfig cyc%0d got=%b want=%b", i + 1, {clk_out, tick}, exp);
            else pass_cnt++;
            if (i == 2) begin
                total++;
                if ({pend, cfg_ready} !== 2'b10) $display("FAIL reconfig_pend got=%b want=10", {pend, cfg_ready});
                else pass_cnt++;
            end
            if (i == 3) begin
                total++;
                if ({pend, cfg_ready} !== 2'b01) $display("FAIL reconfig_apply got=%b want=01", {pend, cfg_ready});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_period(4, 2); push_period(7, 6); push_period(3, 1); push_period(3, 1);
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin cfg_valid = 1'b1; div_in = 7; high_in = 6; end
            if (i == 1) begin div_in = 3; high_in = 1; end
            if (i == 5) cfg_valid = 1'b0;
            step(); exp = exp_q.pop_front(); total++;
            if ({clk_out, tick} !== exp) $display("FAIL b2b cyc%0d got=%b want=%b", i + 1, {clk_out, tick}, exp);
            else pass_cnt++;
            if (i < 3) begin
                total++;
                if (cfg_ready !== 1'b0) $display("FAIL b2b_stall cyc%0d got=%b want=0", i + 1, cfg_ready);
                else pass_cnt++;
            end
            if (i == 3 || i == 10) begin
                total++;
                if (pend !== 1'b0) $display("FAIL b2b_applied cyc%0d got=%b want=0", i + 1, pend);
                else pass_cnt++;
            end
            if (i == 4) begin
                total++;
                if (pend !== 1'b1) $display("FAIL b2b_second_accept got=%b want=1", pend);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        push_period(4, 2); push_period(4, 2);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin cfg_valid = 1'b1; div_in = 1; high_in = 0; end
            if (i == 1) begin div_in = 4; high_in = 4; end
            if (i == 2) cfg_valid = 1'b0;
            step(); exp = exp_q.pop_front(); total++;
            if ({clk_out, tick} !== exp) $display("FAIL illegal cyc%0d got=%b want=%b", i + 1, {clk_out, tick}, exp);
            else pass_cnt++;
            if (i < 3) begin
                total++;
                if ({cfg_err, pend} !== {1'(i < 2), 1'b0})
                    $display("FAIL illegal_err cyc%0d got=%b want=%b", i + 1, {cfg_err, pend}, {1'(i < 2), 1'b0});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        exp_q.push_back(2'b11); exp_q.push_back(2'b10);
        push_idle(3); push_period(3, 1); push_period(3, 1);
        for (int i = 0; i < 11; i++) begin
            if (i == 2) begin en = 1'b0; cfg_valid = 1'b1; div_in = 3; high_in = 0; end
            if (i == 3) cfg_valid = 1'b0;
            if (i == 5) en = 1'b1;
            step(); exp = exp_q.pop_front(); total++;
            if ({clk_out, tick} !== exp) $display("FAIL enable cyc%0d got=%b want=%b", i + 1, {clk_out, tick}, exp);
            else pass_cnt++;
            if (i == 2 || i == 3) begin
                total++;
                if (pend !== 1'(i == 2)) $display("FAIL idle_apply cyc%0d got=%b want=%b", i + 1, pend, 1'(i == 2));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_with_pend();
        do_reset();
        step(); cfg_valid = 1'b1; div_in = 5; high_in = 0;
        step(); cfg_valid = 1'b0;
        total++;
        if (pend !== 1'b1) $display("FAIL rst_pend_setup got=%b want=1", pend);
        else pass_cnt++;
        rst = 1'b1;
        step();
        total++;
        if ({clk_out, tick, cfg_err, pend, cfg_ready} !== 5'b00001)
            $display("FAIL rst_mid_pend got=%b want=00001", {clk_out, tick, cfg_err, pend, cfg_ready});
        else pass_cnt++;
        rst = 1'b0;
        push_period(4, 2); push_period(4, 2); push_period(4, 2);
        for (int i = 0; i < 12; i++) begin
            step(); exp = exp_q.pop_front(); total++;
            if ({clk_out, tick} !== exp) $display("FAIL rst_defaults cyc%0d got=%b want=%b", i + 1, {clk_out, tick}, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_reconfig_mid_period();
        test_back_to_back();
        test_illegal();
        test_enable();
        test_reset_with_pend();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
